// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - direction turn queue and move-tick generator for the snake datapath
//
// Turns debounced button pulses into a legal direction stream and produces the
// move tick. The move period shrinks as the snake grows.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   q_Run        game running; low holds the counter at 0 and flushes the queue
//   BtnU_Pulse   single-cycle press, up    (highest priority)
//   BtnD_Pulse   single-cycle press, down
//   BtnL_Pulse   single-cycle press, left
//   BtnR_Pulse   single-cycle press, right (lowest priority)
//   Length       current snake length
//   In_Dirn      committed direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
//   SCEN         1-cycle strobe, In_Dirn valid for the coming move
//   Speed_Clk    1-cycle move tick, always one cycle after SCEN
//   Queue_Count  number of pending turns, 0..2
module snake_dir_ctrl #(
    parameter int BASE_PERIOD = 25000000,
    parameter int STEP        = 250000,
    parameter int MIN_PERIOD  = 5000000,
    parameter int CNT_W       = 25
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       q_Run,
    input  logic       BtnU_Pulse,
    input  logic       BtnD_Pulse,
    input  logic       BtnL_Pulse,
    input  logic       BtnR_Pulse,
    input  logic [7:0] Length,
    output logic [1:0] In_Dirn,
    output logic       SCEN,
    output logic       Speed_Clk,
    output logic [1:0] Queue_Count
);

    localparam int WW = CNT_W + 8;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [WW-1:0]    eff_len;
    logic [WW-1:0]    dec;
    logic [CNT_W-1:0] p_calc;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] p_nxt;
    logic             scen_set;
    logic             spd_set;

    logic [1:0] q0_q, q1_q;        // q0 is the head (oldest), q1 the second entry
    logic [1:0] q0_nxt, q1_nxt;
    logic [1:0] cnt_qd_nxt;
    logic [1:0] dir_nxt;
    logic [1:0] cand;
    logic       cand_v;
    logic [1:0] ref_dir;
    logic       accept;

    // Period from length. The comparison is done before subtracting so a long
    // snake can never wrap the unsigned result.
    always_comb begin
        eff_len = (Length < 8'd3) ? WW'(3) : WW'(Length);
        dec     = (eff_len - WW'(3)) * WW'(STEP);
        if (dec + WW'(MIN_PERIOD) > WW'(BASE_PERIOD))
            p_calc = CNT_W'(MIN_PERIOD);
        else
            p_calc = CNT_W'(WW'(BASE_PERIOD) - dec);
    end

    // Strobes are decided from the counter value of the next cycle so that they
    // are registered yet coincide with the matching counter value. A new period
    // is picked up whenever the counter enters 0, so it governs that whole
    // interval, including the first strobe.
    always_comb begin
        cnt_nxt = '0;
        if (q_Run && (cnt_q != period_q - ONE))
            cnt_nxt = cnt_q + ONE;
        p_nxt    = (cnt_nxt == '0) ? p_calc : period_q;
        scen_set = q_Run && (cnt_nxt == p_nxt - TWO);
        spd_set  = q_Run && (cnt_nxt == p_nxt - ONE);
    end

    // Turn queue: pop first, then judge the press against the post-pop state.
    always_comb begin
        dir_nxt    = In_Dirn;
        q0_nxt     = q0_q;
        q1_nxt     = q1_q;
        cnt_qd_nxt = Queue_Count;
        cand       = 2'b00;
        cand_v     = 1'b1;
        ref_dir    = 2'b00;
        accept     = 1'b0;

        if (scen_set && (Queue_Count != 2'd0)) begin
            dir_nxt    = q0_q;
            q0_nxt     = q1_q;
            cnt_qd_nxt = Queue_Count - 2'd1;
        end

        if (BtnU_Pulse)      cand = 2'b00;
        else if (BtnD_Pulse) cand = 2'b01;
        else if (BtnL_Pulse) cand = 2'b10;
        else if (BtnR_Pulse) cand = 2'b11;
        else                 cand_v = 1'b0;

        // Reference is the youngest pending turn, else the committed direction.
        if (cnt_qd_nxt == 2'd2)      ref_dir = q1_nxt;
        else if (cnt_qd_nxt == 2'd1) ref_dir = q0_nxt;
        else                         ref_dir = dir_nxt;

        // Same axis (bit1 equal) means either a duplicate or a reversal.
        accept = q_Run && cand_v && (cand[1] != ref_dir[1]) && (cnt_qd_nxt != 2'd2);

        if (accept) begin
            if (cnt_qd_nxt == 2'd0) q0_nxt = cand;
            else                    q1_nxt = cand;
            cnt_qd_nxt = cnt_qd_nxt + 2'd1;
        end

        if (!q_Run)
            cnt_qd_nxt = 2'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q       <= '0;
            period_q    <= CNT_W'(BASE_PERIOD);
            SCEN        <= 1'b0;
            Speed_Clk   <= 1'b0;
            In_Dirn     <= 2'b00;
            q0_q        <= 2'b00;
            q1_q        <= 2'b00;
            Queue_Count <= 2'd0;
        end else begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt == '0)
                period_q <= p_calc;
            SCEN        <= scen_set;
            Speed_Clk   <= spd_set;
            In_Dirn     <= dir_nxt;
            q0_q        <= q0_nxt;
            q1_q        <= q1_nxt;
            Queue_Count <= cnt_qd_nxt;
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - self-checking bench for snake_dir_ctrl
module tb_snake_dir_ctrl;

    localparam int BASE = 10;
    localparam int STP  = 2;
    localparam int MINP = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       q_Run = 1'b0;
    logic       BtnU_Pulse = 1'b0;
    logic       BtnD_Pulse = 1'b0;
    logic       BtnL_Pulse = 1'b0;
    logic       BtnR_Pulse = 1'b0;
    logic [7:0] Length = 8'd3;
    logic [1:0] In_Dirn;
    logic       SCEN;
    logic       Speed_Clk;
    logic [1:0] Queue_Count;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_pos;
    int m_per;
    int m_dir;
    int m_q[$];
    int m_scen;
    int m_spd;

    snake_dir_ctrl #(
        .BASE_PERIOD(BASE),
        .STEP(STP),
        .MIN_PERIOD(MINP),
        .CNT_W(8)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .q_Run(q_Run),
        .BtnU_Pulse(BtnU_Pulse),
        .BtnD_Pulse(BtnD_Pulse),
        .BtnL_Pulse(BtnL_Pulse),
        .BtnR_Pulse(BtnR_Pulse),
        .Length(Length),
        .In_Dirn(In_Dirn),
        .SCEN(SCEN),
        .Speed_Clk(Speed_Clk),
        .Queue_Count(Queue_Count)
    );

    always #5 Clk = ~Clk;

    function automatic int calc_period(input int len);
        int e;
        int p;
        e = (len < 3) ? 3 : len;
        p = BASE - (e - 3) * STP;
        if (p < MINP) p = MINP;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One move interval is a list of positions 0..P-1; the SCEN slot is P-2
    // and the tick slot P-1. Presses are judged after any pop in that edge.
    task automatic model_update();
        int cand;
        int r;
        if (Reset) begin
            m_pos = 0; m_per = BASE; m_dir = 0; m_q.delete(); m_scen = 0; m_spd = 0;
        end else if (!q_Run) begin
            m_pos = 0; m_per = calc_period(int'(Length)); m_q.delete(); m_scen = 0; m_spd = 0;
        end else begin
            m_pos = (m_pos == m_per - 1) ? 0 : m_pos + 1;
            if (m_pos == 0) m_per = calc_period(int'(Length));
            m_scen = (m_pos == m_per - 2) ? 1 : 0;
            m_spd  = (m_pos == m_per - 1) ? 1 : 0;
            if (m_scen == 1 && m_q.size() > 0) m_dir = m_q.pop_front();
            cand = BtnU_Pulse ? 0 : BtnD_Pulse ? 1 : BtnL_Pulse ? 2 : BtnR_Pulse ? 3 : -1;
            if (cand >= 0) begin
                r = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
                if (cand != r && !((cand / 2) == (r / 2)) && m_q.size() < 2)
                    m_q.push_back(cand);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_update();
        #1;
        chk("In_Dirn", 32'(In_Dirn), 32'(m_dir));
        chk("SCEN", 32'(SCEN), 32'(m_scen));
        chk("Speed_Clk", 32'(Speed_Clk), 32'(m_spd));
        chk("Queue_Count", 32'(Queue_Count), 32'(m_q.size()));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // mask = {U,D,L,R}, held for one edge
    task automatic press(input logic [3:0] m);
        {BtnU_Pulse, BtnD_Pulse, BtnL_Pulse, BtnR_Pulse} = m;
        step();
        {BtnU_Pulse, BtnD_Pulse, BtnL_Pulse, BtnR_Pulse} = 4'b0000;
    endtask

    // Leaves the bench in "cycle 0": counter 0, q_Run just set.
    task automatic start_run(input logic [7:0] len);
        q_Run = 1'b0; Reset = 1'b1; Length = len;
        step();
        Reset = 1'b0;
        step();
        q_Run = 1'b1;
    endtask

    initial begin
        m_pos = 0; m_per = BASE; m_dir = 0; m_scen = 0; m_spd = 0;

        // reset state
        steps(2);
        chk("rst_dir", 32'(In_Dirn), 32'd0);
        chk("rst_qc", 32'(Queue_Count), 32'd0);
        chk("rst_scen", 32'(SCEN), 32'd0);
        chk("rst_spd", 32'(Speed_Clk), 32'd0);

        // free running at Length=3: SCEN at 8,18,28, tick at 9,19,29
        start_run(8'd3);
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("base_scen", 32'(SCEN), (k % 10 == 8) ? 32'd1 : 32'd0);
            chk("base_spd", 32'(Speed_Clk), (k % 10 == 9) ? 32'd1 : 32'd0);
            chk("base_dir", 32'(In_Dirn), 32'd0);
        end

        // two queued turns, popped at 8 and 18
        start_run(8'd3);
        steps(2);
        press(4'b0010);
        chk("q_after_L", 32'(Queue_Count), 32'd1);
        press(4'b0100);
        chk("q_after_D", 32'(Queue_Count), 32'd2);
        steps(4);
        chk("pop1_dir", 32'(In_Dirn), 32'd2);
        chk("pop1_scen", 32'(SCEN), 32'd1);
        steps(10);
        chk("pop2_dir", 32'(In_Dirn), 32'd1);
        chk("pop2_qc", 32'(Queue_Count), 32'd0);

        // reversal and duplicate rejection
        start_run(8'd3);
        press(4'b0100);
        chk("rev_reject", 32'(Queue_Count), 32'd0);
        press(4'b1000);
        chk("dup_reject", 32'(Queue_Count), 32'd0);

        // full queue drop
        start_run(8'd3);
        steps(2);
        press(4'b0010);
        press(4'b0100);
        press(4'b0001);
        chk("full_drop", 32'(Queue_Count), 32'd2);

        // U+R same cycle, In_Dirn=LEFT, empty queue
        start_run(8'd3);
        steps(2);
        press(4'b0010);
        steps(5);
        chk("left_dir", 32'(In_Dirn), 32'd2);
        chk("left_qc", 32'(Queue_Count), 32'd0);
        press(4'b1001);
        chk("prio_qc", 32'(Queue_Count), 32'd1);
        steps(9);
        chk("prio_dir", 32'(In_Dirn), 32'd0);

        // Length=5 -> period 6
        start_run(8'd5);
        for (int k = 1; k <= 18; k++) begin
            step();
            chk("p6_spd", 32'(Speed_Clk), (k % 6 == 5) ? 32'd1 : 32'd0);
        end

        // Length=7 -> floor 4
        start_run(8'd7);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("p4_spd", 32'(Speed_Clk), (k % 4 == 3) ? 32'd1 : 32'd0);
        end

        // length change at counter 3 takes effect next interval
        start_run(8'd3);
        steps(3);
        Length = 8'd7;
        for (int k = 4; k <= 17; k++) begin
            step();
            chk("mid_len_spd", 32'(Speed_Clk), (k == 9 || k == 13 || k == 17) ? 32'd1 : 32'd0);
        end

        // very long snake must floor without wrap
        start_run(8'd255);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("p255_spd", 32'(Speed_Clk), (k % 4 == 3) ? 32'd1 : 32'd0);
        end

        // reset mid-interval with one queued turn
        start_run(8'd3);
        steps(2);
        press(4'b0010);
        steps(2);
        chk("pre_rst_qc", 32'(Queue_Count), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mrst_qc", 32'(Queue_Count), 32'd0);
        chk("mrst_dir", 32'(In_Dirn), 32'd0);
        chk("mrst_spd", 32'(Speed_Clk), 32'd0);
        steps(12);

        // q_Run dropped mid-interval
        start_run(8'd3);
        steps(2);
        press(4'b0001);
        steps(2);
        q_Run = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("stop_qc", 32'(Queue_Count), 32'd0);
            chk("stop_scen", 32'(SCEN), 32'd0);
            chk("stop_spd", 32'(Speed_Clk), 32'd0);
        end

        // randomized traffic against the model
        start_run(8'd3);
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 399) == 0);
            if (q_Run) q_Run = ($urandom_range(0, 149) != 0);
            else       q_Run = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0)
                Length = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            BtnU_Pulse = ($urandom_range(0, 11) == 0);
            BtnD_Pulse = ($urandom_range(0, 11) == 0);
            BtnL_Pulse = ($urandom_range(0, 11) == 0);
            BtnR_Pulse = ($urandom_range(0, 11) == 0);
            step();
        end
        {BtnU_Pulse, BtnD_Pulse, BtnL_Pulse, BtnR_Pulse} = 4'b0000;
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
